// File: rtl/seq_arith_unit.sv
// seq_arith_unit: clocked add/sub/multiply/divide unit with valid/ready
// handshakes on both sides.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     operation handshake; op, a and b are captured on the accept edge
//   op                      one-hot opcode: 0001 add, 0010 sub, 0100 mul, 1000 div
//   a, b                    operands (A / dividend / multiplicand, B / divisor / multiplier)
//   out_valid / out_ready   result handshake; results are held while out_ready is low
//   result_lo / result_hi   sum|diff|product low|quotient  /  0|product high|remainder
//   carry                   add carry out, sub no-borrow, otherwise 0
//   div_by_zero, illegal_op status flags, meaningful while out_valid is high
//   dbg_state               current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE,
// so a result handoff and a new accept can never share an edge.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opa_q;      // multiplicand
  logic [WIDTH-1:0] opb_q;      // divisor
  // work_hi_q: running product high half (mul) or partial remainder (div).
  // It is WIDTH+1 bits so the remainder shift never overflows.
  logic [WIDTH:0]   work_hi_q;
  // work_lo_q: multiplier shifting out / product low half (mul), or
  // dividend shifting out / quotient shifting in (div).
  logic [WIDTH-1:0] work_lo_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             carry_q;
  logic             dbz_q;
  logic             ill_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_rem_nx;
  logic [WIDTH-1:0] div_quo_nx;

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} one place right.
    mul_sum = work_hi_q;
    if (work_lo_q[0]) begin
      mul_sum = work_hi_q + {1'b0, opa_q};
    end
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, keep the subtraction
    // only when it does not go negative.
    div_shift  = {work_hi_q[WIDTH-1:0], work_lo_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opb_q});
    div_rem_nx = div_shift;
    if (div_ge) begin
      div_rem_nx = div_shift - {1'b0, opb_q};
    end
    div_quo_nx = {work_lo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      carry_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_q <= a;
            opb_q <= b;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            ill_q <= 1'b0;
            case (op)
              4'b0001: begin
                res_lo_q <= add_sum[WIDTH-1:0];
                res_hi_q <= '0;
                carry_q  <= add_sum[WIDTH];
                state_q  <= DONE;
              end
              4'b0010: begin
                res_lo_q <= sub_sum[WIDTH-1:0];
                res_hi_q <= '0;
                carry_q  <= sub_sum[WIDTH];
                state_q  <= DONE;
              end
              4'b0100: begin
                work_hi_q <= '0;
                work_lo_q <= b;
                state_q   <= MUL;
              end
              4'b1000: begin
                if (b == '0) begin
                  res_lo_q <= '1;
                  res_hi_q <= a;
                  carry_q  <= 1'b0;
                  dbz_q    <= 1'b1;
                  state_q  <= DONE;
                end else begin
                  work_hi_q <= '0;
                  work_lo_q <= a;
                  state_q   <= DIV;
                end
              end
              default: begin
                res_lo_q <= '0;
                res_hi_q <= '0;
                carry_q  <= 1'b0;
                ill_q    <= 1'b1;
                state_q  <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          work_hi_q <= {1'b0, mul_hi_nx};
          work_lo_q <= mul_lo_nx;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            res_lo_q <= mul_lo_nx;
            res_hi_q <= mul_hi_nx;
            carry_q  <= 1'b0;
            state_q  <= DONE;
          end
        end
        DIV: begin
          work_hi_q <= div_rem_nx;
          work_lo_q <= div_quo_nx;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            res_lo_q <= div_quo_nx;
            res_hi_q <= div_rem_nx[WIDTH-1:0];
            carry_q  <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Testbench for seq_arith_unit: directed steps plus randomized operations,
// checked against an arithmetic reference model. One 8-bit and one 16-bit
// instance share the clock and reset.
module tb_seq_arith_unit;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [7:0]  a, b, result_lo, result_hi;
  logic        carry, div_by_zero, illegal_op;
  logic [1:0]  dbg_state;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, result_lo16, result_hi16;
  logic        carry16, div_by_zero16, illegal_op16;
  logic [1:0]  dbg_state16;

  int n_cmp = 0;
  int n_bad = 0;

  seq_arith_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .carry(carry),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  seq_arith_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result_lo(result_lo16), .result_hi(result_hi16), .carry(carry16),
    .div_by_zero(div_by_zero16), .illegal_op(illegal_op16), .dbg_state(dbg_state16)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model, straight from the arithmetic definitions
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int w, output logic [31:0] lo, output logic [31:0] hi,
                       output logic c, output logic dz, output logic il, output int lat);
    logic [63:0] mask, s, p;
    mask = (64'd1 << w) - 64'd1;
    lo = '0; hi = '0; c = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
    case (o)
      4'b0001: begin s = 64'(x) + 64'(y); lo = 32'(s & mask); c = s[w]; end
      4'b0010: begin lo = 32'((64'(x) - 64'(y)) & mask); c = (x >= y); end
      4'b0100: begin
        p = 64'(x) * 64'(y);
        lo = 32'(p & mask); hi = 32'((p >> w) & mask); lat = w + 1;
      end
      4'b1000: begin
        if (y == 0) begin lo = 32'(mask); hi = x; dz = 1'b1; end
        else begin lo = x / y; hi = x % y; lat = w + 1; end
      end
      default: il = 1'b1;
    endcase
  endtask

  // driver for the 8-bit instance: issue, wait, check, optionally hold, hand off.
  // Called at posedge+1 with the unit idle.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input int hold, input logic push_during_hold);
    logic [31:0] elo, ehi;
    logic ec, edz, eil;
    int elat, cyc;
    logic [7:0] exp_q[$];
    model(o, 32'(x), 32'(y), 8, elo, ehi, ec, edz, eil, elat);
    exp_q.push_back(elo[7:0]);
    exp_q.push_back(ehi[7:0]);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(elat));
    chk({tag, ".lo"}, 64'(result_lo), 64'(exp_q[0]));
    chk({tag, ".hi"}, 64'(result_hi), 64'(exp_q[1]));
    chk({tag, ".carry"}, 64'(carry), 64'(ec));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
    chk({tag, ".ill"}, 64'(illegal_op), 64'(eil));
    if (push_during_hold) begin
      in_valid = 1'b1; op = 4'b0001; a = 8'h11; b = 8'h22;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_res"}, {48'd0, result_hi, result_lo}, {48'd0, exp_q[1], exp_q[0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".handoff_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".handoff_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_op16(input string tag, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y);
    logic [31:0] elo, ehi;
    logic ec, edz, eil;
    int elat, cyc;
    model(o, 32'(x), 32'(y), 16, elo, ehi, ec, edz, eil, elat);
    in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 1;
    while (out_valid16 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(elat));
    chk({tag, ".res"}, {32'd0, result_hi16, result_lo16}, {32'd0, ehi[15:0], elo[15:0]});
    chk({tag, ".flags"}, 64'({carry16, div_by_zero16, illegal_op16}), 64'({ec, edz, eil}));
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    chk({tag, ".handoff"}, 64'({out_valid16, in_ready16}), 64'b01);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".res"}, {48'd0, result_hi, result_lo}, 64'd0);
    chk({tag, ".flags"}, 64'({carry, div_by_zero, illegal_op}), 64'd0);
    chk({tag, ".state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    logic [3:0] ill_codes [5];
    logic [3:0] ro;
    logic [7:0] ra, rb;
    int k;
    ill_codes[0] = 4'b0000; ill_codes[1] = 4'b0011; ill_codes[2] = 4'b1100;
    ill_codes[3] = 4'b1111; ill_codes[4] = 4'b0110;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    #2;
    chk_reset_state("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_ff_01", 4'b0001, 8'hFF, 8'h01, 0, 1'b0);
    do_op("sub_05_07", 4'b0010, 8'h05, 8'h07, 0, 1'b0);
    do_op("sub_07_05", 4'b0010, 8'h07, 8'h05, 0, 1'b0);
    do_op("mul_ff_ff", 4'b0100, 8'hFF, 8'hFF, 0, 1'b0);
    do_op("mul_0d_0b", 4'b0100, 8'h0D, 8'h0B, 0, 1'b0);
    do_op("div_c8_07", 4'b1000, 8'hC8, 8'h07, 0, 1'b0);
    do_op("div_09_00", 4'b1000, 8'h09, 8'h00, 0, 1'b0);
    do_op("illegal_0011", 4'b0011, 8'h12, 8'h34, 0, 1'b0);
    do_op("backpressure_mul", 4'b0100, 8'hFF, 8'hFF, 20, 1'b1);

    // reset in the middle of a multiply: four iterations in, then abort
    in_valid = 1'b1; op = 4'b0100; a = 8'hAB; b = 8'hCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_mul.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_mul_reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset.no_result", 64'(out_valid), 64'd0);
    do_op("div_40_08", 4'b1000, 8'h40, 8'h08, 0, 1'b0);

    // randomized operations with random backpressure
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      ra = 8'($urandom);
      rb = 8'($urandom);
      case (k)
        0: ro = 4'b0001;
        1: ro = 4'b0010;
        2: ro = 4'b0100;
        3: ro = 4'b1000;
        4: ro = ill_codes[$urandom_range(0, 4)];
        default: begin ro = 4'b1000; rb = 8'h00; end
      endcase
      do_op("random", ro, ra, rb, $urandom_range(0, 3), 1'b0);
    end

    // 16-bit instance
    do_op16("w16_mul_ffff", 4'b0100, 16'hFFFF, 16'hFFFF);
    do_op16("w16_div", 4'b1000, 16'hBEEF, 16'h0123);
    for (int n = 0; n < 8; n++) begin
      do_op16("w16_random", 4'b0001 << $urandom_range(0, 3), 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
